// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch queue: bus widths, reset PC and
// the entry layout handed from IF to ID.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam int          IF_ID_BUS_W      = 64;
  localparam int          ID_IF_BUS_W      = 33;
  localparam logic [1:0]  SIZE_WORD        = 2'b10;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_entry_t;

  function automatic logic [31:0] pc_advance(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// Small synchronous FIFO with occupancy count, head-of-queue output and a
// synchronous clear. Pointers wrap explicitly so DEPTH need not be a power of 2.
module if_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH-1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  // Next-state: a push into a full FIFO is only honoured if a pop frees a slot.
  always_comb begin
    do_pop_s  = pop & (count_q != {CW{1'b0}});
    do_push_s = push & ((count_q != CW'(DEPTH)) | do_pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clr) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: issues pipelined word reads, tracks in-flight PCs,
// buffers returned instructions for ID and discards stale returns after redirects.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int          IBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   inst_sram_req,
  output logic                   inst_sram_wr,
  output logic [1:0]             inst_sram_size,
  output logic [3:0]             inst_sram_wstrb,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata,
  input  logic                   id_allowin,
  input  logic [ID_IF_BUS_W-1:0] id_to_if_bus,
  input  logic [31:0]            wb_to_if_bus,
  input  logic                   flush,
  output logic                   if_to_id_valid,
  output logic [IF_ID_BUS_W-1:0] if_to_id_bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int CW = $clog2(IBUF_DEPTH+1);
  localparam int SW = CW + 1;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] discard_q, discard_d;

  logic         redirect_s, accept_s, rsp_s, discarding_s;
  logic         ibuf_push_s, ibuf_pop_s;
  logic [31:0]  target_s, inflight_pc_s;
  logic [OW-1:0] outstanding_s;
  logic [CW-1:0] ibuf_count_s;
  logic [SW-1:0] occupancy_s;
  if_id_entry_t ibuf_din_s, ibuf_head_s;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0000_0000;
  assign inst_sram_addr  = fetch_pc_q;
  assign if_to_id_bus    = ibuf_head_s;

  // Request gating reserves a buffer slot for every in-flight fetch, so
  // data_ok never needs backpressure.
  always_comb begin
    redirect_s     = flush | id_to_if_bus[32];
    target_s       = flush ? wb_to_if_bus : id_to_if_bus[31:0];
    occupancy_s    = SW'(ibuf_count_s) + SW'(outstanding_s);
    inst_sram_req  = resetn & ~redirect_s
                   & (outstanding_s < OW'(MAX_OUTSTANDING))
                   & (occupancy_s < SW'(IBUF_DEPTH));
    accept_s       = inst_sram_req & inst_sram_addr_ok;
    rsp_s          = inst_sram_data_ok & (outstanding_s != {OW{1'b0}});
    discarding_s   = (discard_q != {OW{1'b0}});
    ibuf_push_s    = rsp_s & ~discarding_s & ~redirect_s;
    if_to_id_valid = (ibuf_count_s != {CW{1'b0}}) & ~redirect_s;
    ibuf_pop_s     = if_to_id_valid & id_allowin;
    ibuf_din_s     = '{inst: inst_sram_rdata, pc: inflight_pc_s};

    if (redirect_s) begin
      fetch_pc_d = target_s;
    end else if (accept_s) begin
      fetch_pc_d = pc_advance(fetch_pc_q);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    // After a redirect everything still in flight next cycle belongs to the old path.
    if (redirect_s) begin
      discard_d = outstanding_s + OW'(accept_s) - OW'(rsp_s);
    end else if (rsp_s & discarding_s) begin
      discard_d = discard_q - OW'(1'b1);
    end else begin
      discard_d = discard_q;
    end
  end

  // Fetch PC and stale-return counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= {OW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  if_sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clr    (1'b0),
    .push   (accept_s),
    .din    (fetch_pc_q),
    .pop    (rsp_s),
    .count  (outstanding_s),
    .head   (inflight_pc_s)
  );

  if_sync_fifo #(
    .WIDTH (IF_ID_BUS_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk    (clk),
    .resetn (resetn),
    .clr    (redirect_s),
    .push   (ibuf_push_s),
    .din    (ibuf_din_s),
    .pop    (ibuf_pop_s),
    .count  (ibuf_count_s),
    .head   (ibuf_head_s)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed table and corner sequences
// plus random traffic, all checked against a queue-based reference model.
module tb_if_fetch_queue;

  localparam logic [31:0] RPC   = 32'h1c00_0000;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        id_allowin = 1'b0;
  logic [32:0] id_to_if_bus = 33'h0;
  logic [31:0] wb_to_if_bus = 32'h0;
  logic        flush = 1'b0;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;

  if_fetch_queue dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .id_allowin        (id_allowin),
    .id_to_if_bus      (id_to_if_bus),
    .wb_to_if_bus      (wb_to_if_bus),
    .flush             (flush),
    .if_to_id_valid    (if_to_id_valid),
    .if_to_id_bus      (if_to_id_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: in-flight fetches carry a stale flag set by redirects.
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } fl_t;

  fl_t         inflight[$];
  logic [63:0] ibuf[$];
  logic [31:0] memq[$];
  logic [31:0] m_pc;
  bit          e_req, e_valid, redir;

  typedef struct {
    bit          aok, dok, alw;
    bit          ereq;
    logic [31:0] eaddr;
    bit          evalid;
    logic [31:0] epc;
  } tv_t;
  tv_t tv[5];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'ha5a5_5a5a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit aok, input bit dok, input bit alw, input bit br,
                       input logic [31:0] btgt, input bit fl, input logic [31:0] wtgt);
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dok && (memq.size() > 0);
    inst_sram_rdata   = (memq.size() > 0) ? inst_of(memq[0]) : $urandom;
    id_allowin        = alw;
    id_to_if_bus      = {br, btgt};
    flush             = fl;
    wb_to_if_bus      = wtgt;
    #1;
  endtask

  task automatic model_check();
    int st;
    redir   = flush | id_to_if_bus[32];
    e_req   = !redir && (inflight.size() < MAXO) && (ibuf.size() + inflight.size() < DEPTH);
    e_valid = (ibuf.size() > 0) && !redir;
    chk("req", 64'(inst_sram_req), 64'(e_req));
    chk("addr", 64'(inst_sram_addr), 64'(m_pc));
    chk("valid", 64'(if_to_id_valid), 64'(e_valid));
    if (e_valid) chk("bus", if_to_id_bus, ibuf[0]);
    st = 0;
    foreach (inflight[i]) if (inflight[i].stale) st++;
    chk("discard_cnt", 64'(dut.discard_q), 64'(st));
    chk("outstanding", 64'(dut.outstanding_s), 64'(inflight.size()));
    chk("ibuf_count", 64'(dut.ibuf_count_s), 64'(ibuf.size()));
  endtask

  task automatic advance();
    fl_t e;
    bit  acc;
    acc = e_req && inst_sram_addr_ok;
    if (inst_sram_req && inst_sram_addr_ok) memq.push_back(inst_sram_addr);
    if (redir) ibuf.delete();
    else if (e_valid && id_allowin) void'(ibuf.pop_front());
    if (inst_sram_data_ok) begin
      void'(memq.pop_front());
      if (inflight.size() > 0) begin
        e = inflight.pop_front();
        if (!e.stale && !redir) ibuf.push_back({inst_sram_rdata, e.pc});
      end
    end
    if (redir) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      m_pc = flush ? wb_to_if_bus : id_to_if_bus[31:0];
    end else if (acc) begin
      e.pc = m_pc;
      e.stale = 1'b0;
      inflight.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input bit aok, input bit dok, input bit alw, input bit br,
                     input logic [31:0] btgt, input bit fl, input logic [31:0] wtgt);
    drive(aok, dok, alw, br, btgt, fl, wtgt);
    model_check();
    advance();
  endtask

  // Asserts reset just after a falling edge, checks reset state, releases on the next falling edge.
  task automatic reset_dut();
    resetn = 1'b0;
    #2;
    inflight.delete();
    ibuf.delete();
    memq.delete();
    m_pc = RPC;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    id_allowin = 1'b0;
    id_to_if_bus = 33'h0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req", 64'(inst_sram_req), 64'(1'b0));
    chk("rst_valid", 64'(if_to_id_valid), 64'(1'b0));
    chk("rst_addr", 64'(inst_sram_addr), 64'(RPC));
    chk("rst_outstanding", 64'(dut.outstanding_s), 64'(0));
    chk("rst_discard", 64'(dut.discard_q), 64'(0));
    chk("rst_ibuf_count", 64'(dut.ibuf_count_s), 64'(0));
    chk("const_bits", 64'({inst_sram_wr, inst_sram_size, inst_sram_wstrb}), 64'(7'b0_10_0000));
    chk("const_wdata", 64'(inst_sram_wdata), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          got;
    logic [31:0] t;

    tv[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h1c00_0000, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1c00_0004, 1'b0, 32'h0};
    tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1c00_0008, 1'b1, 32'h1c00_0000};
    tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1c00_000c, 1'b1, 32'h1c00_0004};
    tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1c00_0010, 1'b1, 32'h1c00_0008};

    @(negedge clk);
    reset_dut();

    // Streaming from reset: one instruction per cycle.
    for (int i = 0; i < 5; i++) begin
      drive(tv[i].aok, tv[i].dok, tv[i].alw, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("tbl_req", 64'(inst_sram_req), 64'(tv[i].ereq));
      chk("tbl_addr", 64'(inst_sram_addr), 64'(tv[i].eaddr));
      chk("tbl_valid", 64'(if_to_id_valid), 64'(tv[i].evalid));
      if (tv[i].evalid) chk("tbl_bus", if_to_id_bus, {inst_of(tv[i].epc), tv[i].epc});
      model_check();
      advance();
    end

    // Branch with two fetches outstanding: both returns dropped.
    reset_dut();
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h1c00_0100, 1'b0, 32'h0);
    #1;
    chk("r023_discard", 64'(dut.discard_q), 64'(2));
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      if (if_to_id_valid) begin
        got = 1'b1;
        chk("r023_first_pc", 64'(if_to_id_bus[31:0]), 64'(32'h1c00_0100));
      end
      model_check();
      advance();
    end
    chk("r023_delivered", 64'(got), 64'(1'b1));

    // Flush and branch together: flush target wins, buffer cleared.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1c00_0200, 1'b1, 32'h1c00_8000);
    chk("r024_valid", 64'(if_to_id_valid), 64'(1'b0));
    model_check();
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("r024_addr", 64'(inst_sram_addr), 64'(32'h1c00_8000));
    chk("r024_ibuf", 64'(dut.ibuf_count_s), 64'(0));
    model_check();
    advance();

    // PC wraps at the top of the address space.
    reset_dut();
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hffff_fffc, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("r025_addr_top", 64'(inst_sram_addr), 64'(32'hffff_fffc));
    chk("r025_req", 64'(inst_sram_req), 64'(1'b1));
    model_check();
    advance();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("r025_addr_wrap", 64'(inst_sram_addr), 64'(32'h0));
    model_check();
    advance();

    // ID stalled: buffer fills to depth, requests stop, then drains in order.
    reset_dut();
    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("r022_full", 64'(dut.ibuf_count_s), 64'(DEPTH));
    chk("r022_req", 64'(inst_sram_req), 64'(1'b0));
    model_check();
    advance();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("r022_resume_pc", 64'(if_to_id_bus[31:0]), 64'(RPC));
    model_check();
    advance();
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset with fetches in flight and entries buffered.
    reset_dut();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("r026_pre_outstanding", 64'(dut.outstanding_s), 64'(2));
    chk("r026_pre_ibuf", 64'(dut.ibuf_count_s), 64'(2));
    reset_dut();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("r026_first_addr", 64'(inst_sram_addr), 64'(RPC));
    chk("r026_first_req", 64'(inst_sram_req), 64'(1'b1));
    model_check();
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_dut();
      t = $urandom & 32'hffff_fffc;
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
          $urandom_range(0, 99) < 5, t, $urandom_range(0, 99) < 3, t ^ 32'h0000_1000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
